// File: rtl/pwm_gen_pkg.sv
// Shared settings for the PWM generator: alignment encoding and default period width.
package pwm_gen_pkg;

    typedef enum logic {
        PWM_ALIGN_CENTER  = 1'b0,
        PWM_ALIGN_LEADING = 1'b1
    } pwm_align_t;

    localparam int PWM_PERIOD_LOG2 = 9;

endpackage

// File: rtl/pwm_gen_edge_calc.sv
// Registered conversion of one {pulse width, phase, alignment} sample into
// rise/fall counter positions plus constant-level flags.
module pwm_edge_calc
    import pwm_gen_pkg::*;
#(
    parameter int CNT_W   = PWM_PERIOD_LOG2,
    parameter int PHASE_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               mode,
    input  logic [CNT_W:0]     pulse_width,
    input  logic [PHASE_W-1:0] phase,
    output logic               out_valid,
    output logic [CNT_W-1:0]   rise,
    output logic [CNT_W-1:0]   fall,
    output logic               full,
    output logic               zero
);

    localparam logic [CNT_W:0] PERIOD = {1'b1, {CNT_W{1'b0}}};

    pwm_align_t       align;
    logic [CNT_W:0]   pw_clamped;
    logic [CNT_W-1:0] offset;
    logic [CNT_W-1:0] rise_next;
    logic [CNT_W-1:0] fall_next;

    logic             valid_reg;
    logic [CNT_W-1:0] rise_reg;
    logic [CNT_W-1:0] fall_reg;
    logic             full_reg;
    logic             zero_reg;

    // All position arithmetic wraps modulo the period by staying CNT_W bits wide.
    always_comb begin
        align      = pwm_align_t'(mode);
        pw_clamped = (pulse_width > PERIOD) ? PERIOD : pulse_width;
        offset     = CNT_W'(phase) << (CNT_W - PHASE_W);
        if (align == PWM_ALIGN_CENTER) begin
            rise_next = offset - pw_clamped[CNT_W:1];
        end else begin
            rise_next = offset;
        end
        fall_next = rise_next + pw_clamped[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            rise_reg  <= '0;
            fall_reg  <= '0;
            full_reg  <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                rise_reg <= rise_next;
                fall_reg <= fall_next;
                full_reg <= (pw_clamped == PERIOD);
                zero_reg <= (pw_clamped == '0);
            end
        end
    end

    assign out_valid = valid_reg;
    assign rise      = rise_reg;
    assign fall      = fall_reg;
    assign full      = full_reg;
    assign zero      = zero_reg;

endmodule

// File: rtl/pwm_gen.sv
// Multi-channel PWM stage: streamed shadow frame, atomic commit on UPDATE,
// per-channel comparators against the shared period counter.
module pwm_gen
    import pwm_gen_pkg::*;
#(
    parameter int DEPTH   = 249,
    parameter int CNT_W   = PWM_PERIOD_LOG2,
    parameter int PHASE_W = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [CNT_W-1:0]   TIME_CNT,
    input  logic               UPDATE,
    input  logic               MODE,
    input  logic               DIN_VALID,
    input  logic [CNT_W:0]     PULSE_WIDTH,
    input  logic [PHASE_W-1:0] PHASE,
    output logic [DEPTH-1:0]   PWM_OUT,
    output logic               DOUT_VALID,
    output logic               FRAME_DROP,
    output logic               OVERRUN
);

    localparam int               IDX_W     = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] FRAME_LEN = IDX_W'(DEPTH);

    typedef struct packed {
        logic [CNT_W-1:0] rise;
        logic [CNT_W-1:0] fall;
        logic             full;
        logic             zero;
    } entry_t;

    function automatic logic pwm_level(input entry_t e, input logic [CNT_W-1:0] t);
        logic level;
        level = 1'b0;
        if (e.zero) begin
            level = 1'b0;
        end else if (e.full) begin
            level = 1'b1;
        end else if (e.rise < e.fall) begin
            level = (t >= e.rise) && (t < e.fall);
        end else if (e.rise > e.fall) begin
            level = (t >= e.rise) || (t < e.fall);
        end
        return level;
    endfunction

    // Reset asserts asynchronously but releases only on a clock edge.
    logic rst_meta_reg;
    logic rst_sync_reg;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_meta_reg <= 1'b0;
            rst_sync_reg <= 1'b0;
        end else begin
            rst_meta_reg <= 1'b1;
            rst_sync_reg <= rst_meta_reg;
        end
    end

    logic             rst_n_int;
    logic             frame_full;
    logic             commit;
    logic             accept;
    logic [IDX_W-1:0] slot;
    logic [IDX_W-1:0] wr_idx_reg;
    logic [IDX_W-1:0] wr_idx_next;
    logic [IDX_W-1:0] pipe_idx_reg;
    logic             dout_valid_reg;
    logic             frame_drop_reg;
    logic             overrun_reg;

    assign rst_n_int  = rst_sync_reg;
    assign frame_full = (wr_idx_reg == FRAME_LEN);
    assign commit     = UPDATE && frame_full;
    // A sample coincident with UPDATE always opens the next frame at slot 0.
    assign accept     = DIN_VALID && (UPDATE || !frame_full);
    assign slot       = UPDATE ? '0 : wr_idx_reg;

    always_comb begin
        wr_idx_next = wr_idx_reg;
        if (UPDATE) begin
            wr_idx_next = DIN_VALID ? IDX_W'(1) : '0;
        end else if (accept) begin
            wr_idx_next = wr_idx_reg + IDX_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            wr_idx_reg     <= '0;
            pipe_idx_reg   <= '0;
            dout_valid_reg <= 1'b0;
            frame_drop_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            wr_idx_reg     <= wr_idx_next;
            if (accept) begin
                pipe_idx_reg <= slot;
            end
            dout_valid_reg <= commit;
            frame_drop_reg <= UPDATE && !frame_full;
            overrun_reg    <= DIN_VALID && !UPDATE && frame_full;
        end
    end

    logic             calc_valid;
    logic [CNT_W-1:0] calc_rise;
    logic [CNT_W-1:0] calc_fall;
    logic             calc_full;
    logic             calc_zero;
    entry_t           calc_entry;

    pwm_edge_calc #(
        .CNT_W   (CNT_W),
        .PHASE_W (PHASE_W)
    ) u_edge_calc (
        .clk         (CLK),
        .rst_n       (rst_n_int),
        .in_valid    (accept),
        .mode        (MODE),
        .pulse_width (PULSE_WIDTH),
        .phase       (PHASE),
        .out_valid   (calc_valid),
        .rise        (calc_rise),
        .fall        (calc_fall),
        .full        (calc_full),
        .zero        (calc_zero)
    );

    assign calc_entry = {calc_rise, calc_fall, calc_full, calc_zero};

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_chan
        logic   wr_hit;
        entry_t shd_reg;
        entry_t act_reg;
        entry_t src_entry;
        entry_t act_next;
        logic   pwm_reg;

        assign wr_hit = calc_valid && (pipe_idx_reg == IDX_W'(gi));

        // The write still in flight at UPDATE is forwarded so it joins this commit,
        // and the comparator sees the new entry already at TIME_CNT==0.
        always_comb begin
            src_entry = wr_hit ? calc_entry : shd_reg;
            act_next  = commit ? src_entry : act_reg;
        end

        always_ff @(posedge CLK or negedge rst_n_int) begin
            if (!rst_n_int) begin
                shd_reg <= '0;
                act_reg <= '0;
                pwm_reg <= 1'b0;
            end else begin
                if (wr_hit) begin
                    shd_reg <= calc_entry;
                end
                act_reg <= act_next;
                pwm_reg <= pwm_level(act_next, TIME_CNT);
            end
        end

        assign PWM_OUT[gi] = pwm_reg;
    end

    assign DOUT_VALID = dout_valid_reg;
    assign FRAME_DROP = frame_drop_reg;
    assign OVERRUN    = overrun_reg;

endmodule
